// File: rtl/mem_access_if.sv
// Data-memory request/acknowledge bus between the memory stage and data memory.
//   master (memory stage): drives dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata;
//                          samples dmem_ack, dmem_rdata.
//   slave  (data memory):  the reverse.
// A request is held stable from the cycle dmem_req rises until the cycle dmem_ack
// is seen; dmem_rdata is valid in the ack cycle.
interface mem_access_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access.sv
// Memory stage of the pipeline. Takes execute's result (ALU value or effective
// address), store data and rd; performs loads/stores over the dmem bus and emits
// one writeback record per instruction. Non-memory instructions pass through with
// one cycle of latency; memory ops stall upstream until dmem_ack.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   pipeline_in_valid     execute output valid; nop_instr_in marks a bubble
//   exception_in[_valid]  upstream exception code / present
//   opcode_in, funct      opcode[6:2] and funct3
//   result_in, store_data ALU result or effective address; rs2 for stores
//   rd_addr_in            destination register
//   flush_in              squash the instruction at the inputs (ignored while waiting)
//   stall_out             high for the whole memory wait, ack cycle included
//   dmem                  data-memory bus (master side)
//   pipeline_out_valid, wb_en, rd_addr_out, wb_data,
//   exception_out[_valid] writeback record
//
// Build option: define MEM_MISALIGN_EX_EN to trap misaligned half/word accesses
// (no request; exception code 4 for loads, 6 for stores). Without it the low
// address bits below the access size are ignored.
module mem_access #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned EX_W       = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipeline_in_valid,
    input  logic                  nop_instr_in,
    input  logic [EX_W-1:0]       exception_in,
    input  logic                  exception_in_valid,
    input  logic [4:0]            opcode_in,
    input  logic [2:0]            funct,
    input  logic [DATA_W-1:0]     result_in,
    input  logic [DATA_W-1:0]     store_data,
    input  logic [REG_ADDR_W-1:0] rd_addr_in,
    input  logic                  flush_in,
    output logic                  stall_out,
    mem_access_if.master          dmem,
    output logic                  pipeline_out_valid,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] rd_addr_out,
    output logic [DATA_W-1:0]     wb_data,
    output logic [EX_W-1:0]       exception_out,
    output logic                  exception_out_valid
);
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
`ifdef MEM_MISALIGN_EX_EN
    localparam logic [EX_W-1:0] EXC_LD_MISALIGN = EX_W'(4);
    localparam logic [EX_W-1:0] EXC_ST_MISALIGN = EX_W'(6);
`endif

    typedef enum logic       {S_IDLE, S_WAIT} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t r_state, w_state_nxt;

    // Latched copy of the in-flight memory op
    logic [1:0]            r_lo,    w_lo_nxt;
    size_t                 r_size,  w_size_nxt;
    logic                  r_uns,   w_uns_nxt;
    logic                  r_store, w_store_nxt;
    logic [REG_ADDR_W-1:0] r_rd,    w_rd_nxt;

    // Registered outputs
    logic                  r_req,   w_req_nxt;
    logic                  r_we,    w_we_nxt;
    logic [ADDR_W-1:0]     r_addr,  w_addr_nxt;
    logic [3:0]            r_be,    w_be_nxt;
    logic [DATA_W-1:0]     r_wdata, w_wdata_nxt;
    logic                  r_valid, w_valid_nxt;
    logic                  r_wb_en, w_wb_en_nxt;
    logic [REG_ADDR_W-1:0] r_rd_out, w_rd_out_nxt;
    logic [DATA_W-1:0]     r_wb_data, w_wb_data_nxt;
    logic [EX_W-1:0]       r_exc,   w_exc_nxt;
    logic                  r_exc_v, w_exc_v_nxt;

    // Input decode
    logic              w_is_load, w_is_store, w_is_mem;
    size_t             w_size;
    logic [1:0]        w_lo;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic              w_misalign;
    logic              w_accept, w_issue;

    assign w_is_load  = (opcode_in == OP_LOAD);
    assign w_is_store = (opcode_in == OP_STORE);
    assign w_is_mem   = w_is_load | w_is_store;
    assign w_lo       = result_in[1:0];

    // Unsupported funct3 encodings fall back to word size
    assign w_size = w_is_store ? ((funct == 3'b000) ? SZ_BYTE :
                                  (funct == 3'b001) ? SZ_HALF : SZ_WORD)
                               : ((funct[1:0] == 2'b00) ? SZ_BYTE :
                                  (funct[1:0] == 2'b01) ? SZ_HALF : SZ_WORD);

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = store_data;
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << w_lo;
                w_wdata = {4{store_data[7:0]}};
            end
            SZ_HALF: begin
                w_be    = w_lo[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_EX_EN
    assign w_misalign = ((w_size == SZ_HALF) && w_lo[0]) ||
                        ((w_size == SZ_WORD) && (w_lo != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept = (r_state == S_IDLE) && pipeline_in_valid && !flush_in;
    assign w_issue  = w_accept && w_is_mem && !nop_instr_in && !exception_in_valid
                      && !w_misalign;

    // Load data alignment from the latched op
    logic [1:0]        w_off;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_load_data;

    assign w_off     = (r_size == SZ_BYTE) ? r_lo :
                       (r_size == SZ_HALF) ? {r_lo[1], 1'b0} : 2'b00;
    assign w_shifted = dmem.dmem_rdata >> {w_off, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (r_size)
            SZ_BYTE: w_load_data = {{24{!r_uns & w_shifted[7]}},  w_shifted[7:0]};
            SZ_HALF: w_load_data = {{16{!r_uns & w_shifted[15]}}, w_shifted[15:0]};
            default: ;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_lo      <= '0;
            r_size    <= SZ_BYTE;
            r_uns     <= 1'b0;
            r_store   <= 1'b0;
            r_rd      <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_be      <= '0;
            r_wdata   <= '0;
            r_valid   <= 1'b0;
            r_wb_en   <= 1'b0;
            r_rd_out  <= '0;
            r_wb_data <= '0;
            r_exc     <= '0;
            r_exc_v   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lo      <= w_lo_nxt;
            r_size    <= w_size_nxt;
            r_uns     <= w_uns_nxt;
            r_store   <= w_store_nxt;
            r_rd      <= w_rd_nxt;
            r_req     <= w_req_nxt;
            r_we      <= w_we_nxt;
            r_addr    <= w_addr_nxt;
            r_be      <= w_be_nxt;
            r_wdata   <= w_wdata_nxt;
            r_valid   <= w_valid_nxt;
            r_wb_en   <= w_wb_en_nxt;
            r_rd_out  <= w_rd_out_nxt;
            r_wb_data <= w_wb_data_nxt;
            r_exc     <= w_exc_nxt;
            r_exc_v   <= w_exc_v_nxt;
        end
    end

    // Next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_state_nxt = S_WAIT;
            S_WAIT:  if (dmem.dmem_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next values of latched op and outputs
    always_comb begin
        w_lo_nxt      = r_lo;
        w_size_nxt    = r_size;
        w_uns_nxt     = r_uns;
        w_store_nxt   = r_store;
        w_rd_nxt      = r_rd;
        w_req_nxt     = r_req;
        w_we_nxt      = r_we;
        w_addr_nxt    = r_addr;
        w_be_nxt      = r_be;
        w_wdata_nxt   = r_wdata;
        w_valid_nxt   = 1'b0;
        w_wb_en_nxt   = 1'b0;
        w_rd_out_nxt  = r_rd_out;
        w_wb_data_nxt = r_wb_data;
        w_exc_nxt     = r_exc;
        w_exc_v_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_lo_nxt    = w_lo;
                    w_size_nxt  = w_size;
                    w_uns_nxt   = funct[2];
                    w_store_nxt = w_is_store;
                    w_rd_nxt    = rd_addr_in;
                    w_req_nxt   = 1'b1;
                    w_we_nxt    = w_is_store;
                    w_addr_nxt  = {result_in[ADDR_W-1:2], 2'b00};
                    w_be_nxt    = w_be;
                    w_wdata_nxt = w_wdata;
                end else if (w_accept) begin
                    w_valid_nxt   = 1'b1;
                    w_rd_out_nxt  = rd_addr_in;
                    w_wb_data_nxt = result_in;
                    w_exc_nxt     = exception_in;
                    w_exc_v_nxt   = exception_in_valid;
                    w_wb_en_nxt   = !nop_instr_in && !exception_in_valid && !w_is_store
                                    && (rd_addr_in != '0);
`ifdef MEM_MISALIGN_EX_EN
                    if (w_is_mem && !nop_instr_in && !exception_in_valid && w_misalign) begin
                        w_exc_v_nxt = 1'b1;
                        w_exc_nxt   = w_is_store ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
                        w_wb_en_nxt = 1'b0;
                    end
`endif
                end
            end
            S_WAIT: begin
                if (dmem.dmem_ack) begin
                    w_req_nxt    = 1'b0;
                    w_valid_nxt  = 1'b1;
                    w_rd_out_nxt = r_rd;
                    w_wb_en_nxt  = !r_store && (r_rd != '0);
                    if (!r_store) w_wb_data_nxt = w_load_data;
                end
            end
            default: ;
        endcase
    end

    assign stall_out           = (r_state == S_WAIT);
    assign dmem.dmem_req       = r_req;
    assign dmem.dmem_we        = r_we;
    assign dmem.dmem_addr      = r_addr;
    assign dmem.dmem_be        = r_be;
    assign dmem.dmem_wdata     = r_wdata;
    assign pipeline_out_valid  = r_valid;
    assign wb_en               = r_wb_en;
    assign rd_addr_out         = r_rd_out;
    assign wb_data             = r_wb_data;
    assign exception_out       = r_exc;
    assign exception_out_valid = r_exc_v;
endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [4:0] OP_ALU   = 5'b01100;

    logic        clk = 1'b0;
    logic        reset;
    logic        pipeline_in_valid, nop_instr_in, exception_in_valid, flush_in;
    logic [3:0]  exception_in;
    logic [4:0]  opcode_in;
    logic [2:0]  funct;
    logic [31:0] result_in, store_data;
    logic [4:0]  rd_addr_in;
    logic        stall_out, pipeline_out_valid, wb_en, exception_out_valid;
    logic [4:0]  rd_addr_out;
    logic [31:0] wb_data;
    logic [3:0]  exception_out;

    mem_access_if #(.ADDR_W(32), .DATA_W(32)) dmem_bus ();

    mem_access #(.ADDR_W(32), .DATA_W(32), .REG_ADDR_W(5), .EX_W(4)) dut (
        .clk(clk), .reset(reset),
        .pipeline_in_valid(pipeline_in_valid), .nop_instr_in(nop_instr_in),
        .exception_in(exception_in), .exception_in_valid(exception_in_valid),
        .opcode_in(opcode_in), .funct(funct), .result_in(result_in),
        .store_data(store_data), .rd_addr_in(rd_addr_in), .flush_in(flush_in),
        .stall_out(stall_out), .dmem(dmem_bus),
        .pipeline_out_valid(pipeline_out_valid), .wb_en(wb_en),
        .rd_addr_out(rd_addr_out), .wb_data(wb_data),
        .exception_out(exception_out), .exception_out_valid(exception_out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wb_en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic        exv;
        logic [3:0]  exc;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   stall_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Writeback monitor: pops one expected record per valid output
    initial begin
        exp_t e;
        logic bad;
        forever begin
            @(negedge clk);
            if (!reset && pipeline_out_valid) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL wb_unexpected: got valid record rd=%0d data=0x%08h, expected none",
                             rd_addr_out, wb_data);
                end else begin
                    e = sb.pop_front();
                    bad = (wb_en !== e.wb_en) || (rd_addr_out !== e.rd) ||
                          (exception_out_valid !== e.exv) ||
                          (e.chk_data && (wb_data !== e.data)) ||
                          (e.exv && (exception_out !== e.exc));
                    if (bad) begin
                        miscompares++;
                        $display("FAIL wb_record: got en=%0b rd=%0d data=0x%08h exv=%0b exc=%0d expected en=%0b rd=%0d data=0x%08h exv=%0b exc=%0d",
                                 wb_en, rd_addr_out, wb_data, exception_out_valid, exception_out,
                                 e.wb_en, e.rd, e.data, e.exv, e.exc);
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (stall_out) stall_cnt++;
        end
    end

    task automatic push(input logic en, input logic [4:0] rd, input logic [31:0] d,
                        input logic cd, input logic exv, input logic [3:0] exc);
        exp_t e;
        e.wb_en = en; e.rd = rd; e.data = d; e.chk_data = cd; e.exv = exv; e.exc = exc;
        sb.push_back(e);
    endtask

    // Present one instruction for one accepting edge
    task automatic drive(input logic [4:0] op, input logic [2:0] f, input logic [31:0] res,
                         input logic [31:0] sd, input logic [4:0] rd, input logic nop,
                         input logic exv, input logic [3:0] exc, input logic fl);
        opcode_in = op; funct = f; result_in = res; store_data = sd; rd_addr_in = rd;
        nop_instr_in = nop; exception_in_valid = exv; exception_in = exc; flush_in = fl;
        pipeline_in_valid = 1'b1;
        @(posedge clk);
        #1;
        pipeline_in_valid = 1'b0; nop_instr_in = 1'b0; exception_in_valid = 1'b0;
        flush_in = 1'b0;
    endtask

    // Memory op: check the request, ack after `delay` idle wait cycles
    task automatic mem_op(input string name, input logic [4:0] op, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                          input logic [31:0] exp_addr, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] rdata,
                          input int unsigned delay, input logic [31:0] ld_exp,
                          input logic flush_mid);
        int s0;
        logic st;
        st = (op == OP_STORE);
        push(!st && (rd != 5'd0), rd, ld_exp, !st, 1'b0, 4'd0);
        drive(op, f, a, sd, rd, 1'b0, 1'b0, 4'd0, 1'b0);
        s0 = stall_cnt;
        chk({name, "_req"}, {31'd0, dmem_bus.dmem_req}, 32'd1);
        chk({name, "_we"}, {31'd0, dmem_bus.dmem_we}, {31'd0, st});
        chk({name, "_addr"}, dmem_bus.dmem_addr, exp_addr);
        if (st) begin
            chk({name, "_be"}, {28'd0, dmem_bus.dmem_be}, {28'd0, exp_be});
            chk({name, "_wdata"}, dmem_bus.dmem_wdata, exp_wd);
        end
        for (int unsigned i = 0; i < delay; i++) begin
            if (flush_mid && i == 0) flush_in = 1'b1;
            @(posedge clk);
            #1;
            flush_in = 1'b0;
        end
        dmem_bus.dmem_ack = 1'b1;
        dmem_bus.dmem_rdata = rdata;
        @(posedge clk);
        #1;
        dmem_bus.dmem_ack = 1'b0;
        dmem_bus.dmem_rdata = 32'hDEAD_DEAD;
        chk({name, "_req_drop"}, {31'd0, dmem_bus.dmem_req}, 32'd0);
        chk({name, "_stall_cycles"}, stall_cnt - s0, delay + 1);
    endtask

    initial begin
        reset = 1'b1;
        pipeline_in_valid = 0; nop_instr_in = 0; exception_in_valid = 0; flush_in = 0;
        exception_in = 0; opcode_in = 0; funct = 0; result_in = 0; store_data = 0;
        rd_addr_in = 0;
        dmem_bus.dmem_ack = 1'b0;
        dmem_bus.dmem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_req",   {31'd0, dmem_bus.dmem_req}, 32'd0);
        chk("rst_addr",  dmem_bus.dmem_addr, 32'd0);
        chk("rst_valid", {31'd0, pipeline_out_valid}, 32'd0);
        chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
        chk("rst_exv",   {31'd0, exception_out_valid}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_wbdata", wb_data, 32'd0);

        // ALU pass-through
        push(1'b1, 5'd5, 32'h0000_1234, 1'b1, 1'b0, 4'd0);
        drive(OP_ALU, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("add_no_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
        chk("add_valid",  {31'd0, pipeline_out_valid}, 32'd1);

        // Loads and stores
        mem_op("lb",  OP_LOAD,  3'b000, 32'h0000_0103, 32'h0, 5'd7, 32'h0000_0100, 4'b0000,
               32'h0, 32'h80FF_FF00, 3, 32'hFFFF_FF80, 1'b0);
        mem_op("sh",  OP_STORE, 3'b001, 32'h0000_0202, 32'hABCD_1234, 5'd3, 32'h0000_0200,
               4'b1100, 32'h1234_1234, 32'h0, 0, 32'h0, 1'b0);
        mem_op("lh",  OP_LOAD,  3'b001, 32'h0000_0102, 32'h0, 5'd4, 32'h0000_0100, 4'b0000,
               32'h0, 32'h8001_0000, 1, 32'hFFFF_8001, 1'b0);
        mem_op("lhu", OP_LOAD,  3'b101, 32'h0000_0100, 32'h0, 5'd4, 32'h0000_0100, 4'b0000,
               32'h0, 32'h1234_F00D, 0, 32'h0000_F00D, 1'b0);
        mem_op("sb",  OP_STORE, 3'b000, 32'h0000_0101, 32'h0000_0055, 5'd2, 32'h0000_0100,
               4'b0010, 32'h5555_5555, 32'h0, 2, 32'h0, 1'b0);
        mem_op("sw",  OP_STORE, 3'b010, 32'h0000_0104, 32'hCAFE_BABE, 5'd2, 32'h0000_0104,
               4'b1111, 32'hCAFE_BABE, 32'h0, 1, 32'h0, 1'b0);
        // Flush while waiting must not cancel the in-flight load
        mem_op("lbu_flush", OP_LOAD, 3'b100, 32'h0000_0101, 32'h0, 5'd9, 32'h0000_0100,
               4'b0000, 32'h0, 32'h0000_AB00, 2, 32'h0000_00AB, 1'b1);
        // Load to x0 completes without a register write
        mem_op("lw_x0", OP_LOAD, 3'b010, 32'h0000_0040, 32'h0, 5'd0, 32'h0000_0040, 4'b0000,
               32'h0, 32'h7777_7777, 0, 32'h7777_7777, 1'b0);

        // Misaligned word load
`ifdef MEM_MISALIGN_EX_EN
        push(1'b0, 5'd6, 32'h0000_0101, 1'b1, 1'b1, 4'd4);
        drive(OP_LOAD, 3'b010, 32'h0000_0101, 32'h0, 5'd6, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("lw_mis_no_req", {31'd0, dmem_bus.dmem_req}, 32'd0);
`else
        mem_op("lw_mis", OP_LOAD, 3'b010, 32'h0000_0101, 32'h0, 5'd6, 32'h0000_0100, 4'b0000,
               32'h0, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 1'b0);
`endif

        // Flushed ALU op produces nothing
        drive(OP_ALU, 3'd0, 32'h0000_5555, 32'h0, 5'd5, 1'b0, 1'b0, 4'd0, 1'b1);
        chk("flush_valid", {31'd0, pipeline_out_valid}, 32'd0);

        // Bubble on a load opcode: no request, valid record, no write
        push(1'b0, 5'd8, 32'h0000_0300, 1'b1, 1'b0, 4'd0);
        drive(OP_LOAD, 3'b010, 32'h0000_0300, 32'h0, 5'd8, 1'b1, 1'b0, 4'd0, 1'b0);
        chk("nop_no_req", {31'd0, dmem_bus.dmem_req}, 32'd0);

        // Upstream exception passes through and suppresses the write
        push(1'b0, 5'd5, 32'h0000_0777, 1'b1, 1'b1, 4'd2);
        drive(OP_ALU, 3'd0, 32'h0000_0777, 32'h0, 5'd5, 1'b0, 1'b1, 4'd2, 1'b0);

        // ALU op to x0
        push(1'b0, 5'd0, 32'h0000_0999, 1'b1, 1'b0, 4'd0);
        drive(OP_ALU, 3'd0, 32'h0000_0999, 32'h0, 5'd0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Reset in the middle of a memory wait
        drive(OP_LOAD, 3'b010, 32'h0000_0010, 32'h0, 5'd8, 1'b0, 1'b0, 4'd0, 1'b0);
        chk("rw_req_before", {31'd0, dmem_bus.dmem_req}, 32'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("rw_req",   {31'd0, dmem_bus.dmem_req}, 32'd0);
        chk("rw_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        mem_op("lw_after_rst", OP_LOAD, 3'b010, 32'h0000_0020, 32'h0, 5'd8, 32'h0000_0020,
               4'b0000, 32'h0, 32'h1122_3344, 1, 32'h1122_3344, 1'b0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(posedge clk);
        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
